// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Pipeline hazard unit with operand forwarding, load-use and
//                register-scoreboard stalls, and a fixed-latency mul/div
//                tracker. Optional counters: HAZARD_SCOREBOARD_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic              md_op_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [1:0]        result_src_e,
    input  logic              pc_src_e,
    input  logic              md_start_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              md_busy,
    output logic              md_wb_valid,
    output logic [REG_AW-1:0] md_wb_rd
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CW       = $clog2(MD_LAT);

    localparam logic [CW-1:0] C_CNT_INIT = CW'(MD_LAT - 2);
    localparam logic [1:0]    S_IDLE     = 2'd0;
    localparam logic [1:0]    S_BUSY     = 2'd1;
    localparam logic [1:0]    S_DONE     = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [REG_AW-1:0]   r_wb_rd;
    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic                w_accept;
    logic                w_load_use;
    logic                w_sb_haz;
    logic                w_hazard;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic              wem,
        input logic [REG_AW-1:0] rdw,
        input logic              wew,
        input logic [REG_AW-1:0] rdx,
        input logic              wex
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (wem && rdm == rs)      sel = 2'b01;
            else if (wew && rdw == rs) sel = 2'b10;
            else if (wex && rdx == rs) sel = 2'b11;
        end
        return sel;
    endfunction

    // Unit outputs are masked while reset is held so an op caught in DONE never pulses.
    assign md_busy     = !reset && (r_state == S_BUSY);
    assign md_wb_valid = !reset && (r_state == S_DONE);
    assign md_wb_rd    = reset ? '0 : r_wb_rd;

    assign forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w, md_wb_rd, md_wb_valid);
    assign forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w, md_wb_rd, md_wb_valid);

    assign w_accept   = md_start_e && (r_state != S_BUSY);
    assign w_load_use = (result_src_e == 2'b01) && (rd_e != '0) &&
                        ((rs1_d == rd_e) || (rs2_d == rd_e));
    assign w_sb_haz   = ((rs1_d != '0) && r_pending[rs1_d]) ||
                        ((rs2_d != '0) && r_pending[rs2_d]) ||
                        (reg_write_d && (rd_d != '0) && r_pending[rd_d]) ||
                        (md_op_d && md_busy);
    assign w_hazard   = w_load_use || w_sb_haz;

    assign stall_f = !reset && !pc_src_e && w_hazard;
    assign stall_d = !reset && !pc_src_e && w_hazard;
    assign flush_d = !reset && pc_src_e;
    assign flush_e = !reset && (pc_src_e || w_hazard);

    // Clear of the retiring op is applied first so a same-register restart wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_state == S_DONE)
            w_pending_nxt[r_wb_rd] = 1'b0;
        if (w_accept && (rd_e != '0))
            w_pending_nxt[rd_e] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wb_rd   <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_accept) begin
                r_state <= S_BUSY;
                r_cnt   <= C_CNT_INIT;
                r_wb_rd <= rd_e;
            end else begin
                case (r_state)
                    S_BUSY: begin
                        if (r_cnt == '0) r_state <= S_DONE;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (pc_src_e && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench for hazard_scoreboard (MD_LAT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              reg_write_d, md_op_d, pc_src_e, md_start_e, reg_write_m, reg_write_w;
    logic [1:0]        result_src_e;
    logic [1:0]        forward_a_e, forward_b_e;
    logic              stall_f, stall_d, flush_d, flush_e, md_busy, md_wb_valid;
    logic [REG_AW-1:0] md_wb_rd;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]       stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .md_op_d(md_op_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .result_src_e(result_src_e), .pc_src_e(pc_src_e), .md_start_e(md_start_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .md_busy(md_busy), .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {stall_f, stall_d, flush_d, flush_e}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, stall_f, stall_d, flush_d, flush_e}, {28'd0, exp});
    endtask

    task automatic idle_inputs();
        rs1_d = '0; rs2_d = '0; rd_d = '0; reg_write_d = 1'b0; md_op_d = 1'b0;
        rs1_e = '0; rs2_e = '0; rd_e = '0; result_src_e = 2'b00;
        pc_src_e = 1'b0; md_start_e = 1'b0;
        rd_m = '0; rd_w = '0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    endtask

    // Inputs change just after the rising edge; checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        // Load-use pattern during reset must not raise controls.
        result_src_e = 2'b01; rd_e = 5'd5; rs1_d = 5'd5;
        @(negedge clk);
        chk_ctl("reset_ctl", 4'b0000);
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_wbv", {31'd0, md_wb_valid}, 32'd0);
        chk("reset_wbrd", {27'd0, md_wb_rd}, 32'd0);

        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_ctl("load_use_rs1", 4'b1101);
        rd_e = 5'd0; rs1_d = 5'd0; #1;
        chk_ctl("load_use_rd0", 4'b0000);
        rd_e = 5'd5; rs1_d = 5'd5; result_src_e = 2'b10; #1;
        chk_ctl("non_load_src", 4'b0000);
        result_src_e = 2'b01; rs1_d = 5'd0; rs2_d = 5'd5; #1;
        chk_ctl("load_use_rs2", 4'b1101);
        pc_src_e = 1'b1; #1;
        chk_ctl("branch_over_load", 4'b0011);
        idle_inputs();

        rs1_e = 5'd3; rd_m = 5'd3; rd_w = 5'd3; reg_write_m = 1'b1; reg_write_w = 1'b1; #1;
        chk("fwd_m", {30'd0, forward_a_e}, 32'd1);
        reg_write_m = 1'b0; #1;
        chk("fwd_w", {30'd0, forward_a_e}, 32'd2);
        rs1_e = 5'd0; #1;
        chk("fwd_x0", {30'd0, forward_a_e}, 32'd0);
        rs2_e = 5'd3; reg_write_w = 1'b0; #1;
        chk("fwd_no_we", {30'd0, forward_b_e}, 32'd0);
        idle_inputs();

        // Single op on x7; cycle 0 issues, rs2_d=7 from cycle 1.
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) begin md_start_e = 1'b1; rd_e = 5'd7; end
            if (c >= 1) rs2_d = 5'd7;
            if (c == 2) begin pc_src_e = 1'b1; rs1_d = 5'd7; end
            if (c == 3) begin md_start_e = 1'b1; rd_e = 5'd9; end
            if (c == 4) rs1_e = 5'd7;
            if (c == 5) rs1_d = 5'd9;
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), {31'd0, md_busy}, {31'd0, (c >= 1 && c <= 3)});
            chk($sformatf("wbv_c%0d", c), {31'd0, md_wb_valid}, {31'd0, (c == 4)});
            if (c == 2)      chk_ctl("branch_over_sb", 4'b0011);
            else if (c == 5) chk_ctl("release_c5", 4'b0000);
            else             chk_ctl($sformatf("stall_c%0d", c), (c >= 1) ? 4'b1101 : 4'b0000);
            if (c == 4) begin
                chk("wbrd_c4", {27'd0, md_wb_rd}, 32'd7);
                chk("fwd_md", {30'd0, forward_a_e}, 32'd3);
            end
        end

        // Back-to-back on x7: restart in DONE keeps pending and rearms latency.
        for (int c = 0; c <= 9; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0 || c == 4) begin md_start_e = 1'b1; rd_e = 5'd7; end
            if (c == 5 || c == 8 || c == 9) rs1_d = 5'd7;
            if (c == 6) md_op_d = 1'b1;
            if (c == 7) begin reg_write_d = 1'b1; rd_d = 5'd7; end
            @(negedge clk);
            chk($sformatf("b2b_wbv_c%0d", c), {31'd0, md_wb_valid}, {31'd0, (c == 4 || c == 8)});
            if (c == 5) chk_ctl("b2b_pending", 4'b1101);
            if (c == 6) chk_ctl("md_op_busy", 4'b1101);
            if (c == 7) chk_ctl("waw", 4'b1101);
            if (c == 8) chk("b2b_wbrd", {27'd0, md_wb_rd}, 32'd7);
            if (c == 9) chk_ctl("b2b_release", 4'b0000);
        end

        // Reset during BUSY aborts with no writeback.
        for (int c = 0; c <= 7; c++) begin
            next_cycle();
            idle_inputs();
            reset = (c == 2);
            if (c == 0) begin md_start_e = 1'b1; rd_e = 5'd12; end
            if (c >= 3) rs1_d = 5'd12;
            @(negedge clk);
            chk($sformatf("abort_wbv_c%0d", c), {31'd0, md_wb_valid}, 32'd0);
            chk($sformatf("abort_busy_c%0d", c), {31'd0, md_busy}, {31'd0, (c == 1)});
            if (c >= 3) chk_ctl($sformatf("abort_nostall_c%0d", c), 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-address width; NUM_REGS = 2**REG_AW.
REQ-002 Parameter MD_LAT, default 4, mul/div latency in cycles from acceptance to writeback pulse; legal range 2..64.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
REQ-004 Decode-stage inputs:
- rs1_d, rs2_d, rd_d  in  REG_AW  source and destination registers in D.
- reg_write_d  in  1  D instruction writes rd_d.
- md_op_d  in  1  D instruction is a mul/div.
REQ-005 Execute-stage inputs:
- rs1_e, rs2_e, rd_e  in  REG_AW  source and destination registers in E.
- result_src_e  in  2  value 2'b01 marks a load.
- pc_src_e  in  1  taken branch or jump.
- md_start_e  in  1  mul/div issue.
REQ-006 Later-stage inputs: rd_m, rd_w  in  REG_AW; reg_write_m, reg_write_w  in  1.
REQ-007 Outputs:
- forward_a_e, forward_b_e  out  2  operand source select.
- stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls.
- md_busy  out  1  mul/div unit occupied.
- md_wb_valid  out  1  one-cycle writeback pulse.
- md_wb_rd  out  REG_AW  writeback destination register.

Function
REQ-008 Forward select for each E source operand:
- Priority: M match = 2'b01, then W match = 2'b10, then md_wb_valid with md_wb_rd match = 2'b11, else 2'b00.
- A match requires the source register to be nonzero and the matching write-enable to be high.
REQ-009 Load-use hazard: result_src_e==2'b01 and rd_e!=0 and (rs1_d==rd_e or rs2_d==rd_e); result_src_e values other than 2'b01 never trigger it.
REQ-010 Scoreboard: register pending[NUM_REGS-1:0]; pending[0] stays 0 at all times.
REQ-011 Scoreboard hazard, any one of:
- rs1_d or rs2_d is nonzero with its pending bit set.
- reg_write_d, rd_d nonzero, and pending[rd_d] set (WAW).
- md_op_d and md_busy.
REQ-012 Any load-use or scoreboard hazard with pc_src_e=0 SHALL assert stall_f=stall_d=flush_e=1 and flush_d=0, combinationally in the same cycle.
REQ-013 pc_src_e=1 SHALL assert flush_d=flush_e=1 and force stall_f=stall_d=0, overriding every hazard.
REQ-014 FSM states IDLE, BUSY, DONE:
- md_start_e in IDLE or DONE: go to BUSY, counter = MD_LAT-2, capture rd_e into md_wb_rd, set pending[rd_e] if rd_e!=0.
- md_start_e in BUSY is ignored; no state change.
REQ-015 BUSY decrements the counter each cycle and moves to DONE on the cycle after the counter reads 0.
REQ-016 In DONE, md_wb_valid=1 for exactly one cycle, then the FSM returns to IDLE unless REQ-014 applies.
REQ-017 Acceptance-to-md_wb_valid latency SHALL equal MD_LAT cycles.
REQ-018 md_busy=1 only in BUSY.
REQ-019 The pending bit of the completing op SHALL clear at the DONE clock edge. In DONE, set from a new start takes precedence over clear when the register is the same.
REQ-020 Counter width = $clog2(MD_LAT); no wrap-around is permitted.

Reset
REQ-021 During reset: FSM to IDLE, counter=0, pending all 0, md_wb_rd=0; all outputs low except combinational forward selects.
REQ-022 Reset asserted in BUSY or DONE SHALL abort the op with no md_wb_valid pulse.

Configuration
REQ-023 Macro HAZARD_SCOREBOARD_PERF_EN:
- Defined: adds stall_cnt and flush_cnt, each out 32.
- stall_cnt increments on every cycle with stall_d=1; flush_cnt increments on every cycle with pc_src_e=1.
- Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and logic are absent and all other behaviour is identical.

Verification
REQ-024 Load-use: result_src_e=01, rd_e=5, rs1_d=5 -> stall_f=stall_d=flush_e=1, flush_d=0; the same stimulus with rd_e=0 -> no stall.
REQ-025 Forwarding: rs1_e=3, rd_m=3, rd_w=3, both write-enables high -> forward_a_e=01; with reg_write_m=0 -> 10; rs1_e=0 -> 00.
REQ-026 MD_LAT=4: md_start_e with rd_e=7 at cycle 0 ->
- md_busy high cycles 1-3.
- md_wb_valid and md_wb_rd=7 at cycle 4.
- rs2_d=7 stalls cycles 1-4 and releases at cycle 5.
REQ-027 Branch priority: pending[7]=1 with rs1_d=7 and pc_src_e=1 -> stall_f=stall_d=0, flush_d=flush_e=1.
REQ-028 Back-to-back: new md_start_e with rd_e=7 in DONE of an op on x7 -> pending[7] remains 1 and the next md_wb_valid arrives MD_LAT cycles later.
REQ-029 Reset at cycle 2 of a BUSY op -> md_wb_valid is never asserted, pending is all 0, md_busy=0 from the next cycle.
